// File: rtl/ram_arbiter.sv
// ram_arbiter: multi-channel arbiter and access sequencer for one shared
// asynchronous SRAM. Each access walks SETUP -> ACCESS (wait states) -> FINISH,
// and re-arbitrates in FINISH so back-to-back accesses need no idle cycle.
module ram_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int RR_MODE     = 0
) (
    input  logic                       arbi_clk,
    input  logic                       arbi_rst,
    input  logic [NUM_CH-1:0]          arbi_req,
    input  logic [NUM_CH-1:0]          arbi_we,
    input  logic [NUM_CH*ADDR_W-1:0]   arbi_addr,
    input  logic [NUM_CH*DATA_W-1:0]   arbi_wdata,
    output logic [NUM_CH-1:0]          arbo_grant,
    output logic [NUM_CH-1:0]          arbo_done,
    output logic [DATA_W-1:0]          arbo_rdata,
    output logic                       arbo_pause_request,
    output logic                       arbo_ram_en,
    output logic                       arbo_ram_we,
    output logic                       arbo_ram_oe,
    output logic [ADDR_W-1:0]          arbo_ram_addr,
    inout  wire  [DATA_W-1:0]          arbio_ram_data
);

    // A wait-state count of zero would give an ACCESS phase with no strobe,
    // so it is clamped to one.
    localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W = $clog2(W_EFF + 1);
    localparam int IDX_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    sel_q,   sel_d;    // channel being served
    logic [IDX_W-1:0]    ptr_q,   ptr_d;    // last round-robin winner
    logic                we_q,    we_d;     // latched direction
    logic [ADDR_W-1:0]   addr_q,  addr_d;   // latched address
    logic [DATA_W-1:0]   wdata_q, wdata_d;  // latched write data
    logic [DATA_W-1:0]   rdata_q, rdata_d;  // last completed read

    logic                arb_found;
    logic [IDX_W-1:0]    arb_idx;
    logic [NUM_CH-1:0]   arb_req;
    logic                drive_bus;

    // Index wrap for the round-robin search (operands are below 2*NUM_CH).
    function automatic int wrap_idx(input int v);
        return (v >= NUM_CH) ? (v - NUM_CH) : v;
    endfunction

    // Winner selection; only meaningful in IDLE and FINISH. In FINISH the
    // channel just served is masked so it cannot be granted twice in a row
    // on the strength of the request it is still holding.
    always_comb begin
        arb_req   = arbi_req;
        arb_found = 1'b0;
        arb_idx   = '0;
        if (state_q == S_FINISH) begin
            arb_req[sel_q] = 1'b0;
        end
        if (state_q == S_SETUP || state_q == S_ACCESS) begin
            arb_req = '0;
        end
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!arb_found && arb_req[IDX_W'(wrap_idx(int'(ptr_q) + k))]) begin
                    arb_found = 1'b1;
                    arb_idx   = IDX_W'(wrap_idx(int'(ptr_q) + k));
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!arb_found && arb_req[IDX_W'(i)]) begin
                    arb_found = 1'b1;
                    arb_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Next-state logic: sequencing, request latching and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (arb_found) begin
                    state_d = S_SETUP;
                    sel_d   = arb_idx;
                    ptr_d   = arb_idx;
                    we_d    = arbi_we[arb_idx];
                    addr_d  = arbi_addr[arb_idx*ADDR_W +: ADDR_W];
                    wdata_d = arbi_wdata[arb_idx*DATA_W +: DATA_W];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = CNT_W'(W_EFF);
            end
            S_ACCESS: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                    // SRAM output has been valid for the whole strobe window;
                    // sample it on the last ACCESS edge.
                    if (!we_q) begin
                        rdata_d = arbio_ram_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge arbi_clk) begin
        if (arbi_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(NUM_CH - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes, grant and done are decoded from registered state only, so
    // they never glitch on request changes.
    always_comb begin
        arbo_ram_en = (state_q == S_IDLE);
        arbo_ram_oe = !((state_q == S_ACCESS) && !we_q);
        arbo_ram_we = !((state_q == S_ACCESS) && we_q);
        drive_bus   = we_q && ((state_q == S_ACCESS) || (state_q == S_FINISH));
        arbo_grant  = '0;
        arbo_done   = '0;
        if (state_q != S_IDLE) begin
            arbo_grant[sel_q] = 1'b1;
        end
        if (state_q == S_FINISH) begin
            arbo_done[sel_q] = 1'b1;
        end
        arbo_pause_request = |(arbi_req & ~arbo_done);
    end

    assign arbo_ram_addr  = addr_q;
    assign arbo_rdata     = rdata_q;
    // Write data stays on the bus through FINISH for SRAM hold time.
    assign arbio_ram_data = drive_bus ? wdata_q : {DATA_W{1'bz}};

endmodule
